// File: rtl/traffic_fsm_if.sv
// Highway/farm-road sequencer bus: sensor, restart and timer inputs plus light/timer outputs.
// master = surrounding logic (timer, sensor, firmware); slave = the sequencer itself.
interface traffic_fsm_if #(
   parameter int CNT_W = 8
);
   logic             car_in;
   logic             fw_restart;
   logic             short_timeout;
   logic             long_timeout;
   logic [1:0]       hw_light;
   logic [1:0]       fw_light;
   logic             timer_hw_reset;
   logic             timer_fw_reset;
   logic [1:0]       phase;
   logic [CNT_W-1:0] farm_cycles;

   modport master (
      output car_in,
      output fw_restart,
      output short_timeout,
      output long_timeout,
      input  hw_light,
      input  fw_light,
      input  timer_hw_reset,
      input  timer_fw_reset,
      input  phase,
      input  farm_cycles
   );

   modport slave (
      input  car_in,
      input  fw_restart,
      input  short_timeout,
      input  long_timeout,
      output hw_light,
      output fw_light,
      output timer_hw_reset,
      output timer_fw_reset,
      output phase,
      output farm_cycles
   );
endinterface

// File: rtl/traffic_fsm.sv
// Highway/farm-road light sequencer driven by the interval timer, with a debounced car sensor.
// Lights, phase and timer-restart pulses are registered and change on the same edge as the state.
module traffic_fsm #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   traffic_fsm_if.slave  bus
);

   localparam int DW = $clog2(DEBOUNCE + 1);

   localparam logic [1:0] GREEN  = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] RED    = 2'd2;

   typedef enum logic [1:0] {
      HG = 2'd0,
      HY = 2'd1,
      FG = 2'd2,
      FY = 2'd3
   } state_t;

   // ---------------- sensor path ----------------
   logic          sync1_q;
   logic          sync2_q;
   logic          car_q;
   logic [DW-1:0] deb_cnt_q;
   logic [DW-1:0] deb_inc;

   assign deb_inc = deb_cnt_q + DW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         car_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q <= bus.car_in;
         sync2_q <= sync1_q;
         if (sync2_q == car_q) begin
            deb_cnt_q <= '0;
         end else if (deb_inc == DW'(DEBOUNCE)) begin
            car_q     <= sync2_q;
            deb_cnt_q <= '0;
         end else begin
            deb_cnt_q <= deb_inc;
         end
      end
   end

   // ---------------- sequencer ----------------
   state_t           state_q,    state_d;
   logic [1:0]       hw_light_q, hw_light_d;
   logic [1:0]       fw_light_q, fw_light_d;
   logic             hw_rst_q,   hw_rst_d;
   logic             fw_rst_q,   fw_rst_d;
   logic [CNT_W-1:0] farm_q,     farm_d;
   logic             start_q;
   logic             blocked;

   // Timeout levels are stale while a restart pulse is out, so hold the state for that cycle.
   assign blocked = hw_rst_q | fw_rst_q;

   always_comb begin
      state_d  = state_q;
      hw_rst_d = 1'b0;
      fw_rst_d = 1'b0;
      farm_d   = farm_q;
      if (bus.fw_restart) begin
         state_d  = HG;
         fw_rst_d = 1'b1;
      end else begin
         if (!blocked) begin
            case (state_q)
               HG: if (car_q && bus.long_timeout) state_d = HY;
               HY: if (bus.short_timeout)         state_d = FG;
               FG: begin
                  if (!car_q || bus.long_timeout) begin
                     state_d = FY;
                     if (farm_q != '1) farm_d = farm_q + CNT_W'(1);
                  end
               end
               FY: if (bus.short_timeout)         state_d = HG;
               default:                           state_d = HG;
            endcase
         end
         hw_rst_d = start_q || (state_d != state_q);
      end
   end

   always_comb begin
      hw_light_d = GREEN;
      fw_light_d = RED;
      case (state_d)
         HG: begin hw_light_d = GREEN;  fw_light_d = RED;    end
         HY: begin hw_light_d = YELLOW; fw_light_d = RED;    end
         FG: begin hw_light_d = RED;    fw_light_d = GREEN;  end
         FY: begin hw_light_d = RED;    fw_light_d = YELLOW; end
         default: begin hw_light_d = GREEN; fw_light_d = RED; end
      endcase
   end

   // start_q gives the timer one restart pulse on the first edge after reset releases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= HG;
         hw_light_q <= GREEN;
         fw_light_q <= RED;
         hw_rst_q   <= 1'b0;
         fw_rst_q   <= 1'b0;
         farm_q     <= '0;
         start_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         hw_light_q <= hw_light_d;
         fw_light_q <= fw_light_d;
         hw_rst_q   <= hw_rst_d;
         fw_rst_q   <= fw_rst_d;
         farm_q     <= farm_d;
         start_q    <= 1'b0;
      end
   end

   assign bus.hw_light       = hw_light_q;
   assign bus.fw_light       = fw_light_q;
   assign bus.timer_hw_reset = hw_rst_q;
   assign bus.timer_fw_reset = fw_rst_q;
   assign bus.phase          = state_q;
   assign bus.farm_cycles    = farm_q;

endmodule
